// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, framebuffer geometry and the
// decode payload passed between the timing generator and the scanout pipeline.
package vga_pkg;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;
    localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int unsigned H_CNT_W = 10;
    localparam int unsigned V_CNT_W = 10;

    localparam int unsigned FB_W   = 160;
    localparam int unsigned FB_H   = 120;
    localparam int unsigned FB_X_W = $clog2(FB_W);
    localparam int unsigned FB_Y_W = $clog2(FB_H);

    localparam int unsigned SCALE_SHIFT_DEF = 2;

    typedef struct packed {
        logic vis;
        logic hs_n;
        logic vs_n;
        logic fs;
        logic vb;
    } vga_dec_t;

    localparam vga_dec_t DEC_IDLE = '{vis: 1'b0, hs_n: 1'b1, vs_n: 1'b1, fs: 1'b0, vb: 1'b0};

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical counters with their decodes registered once (stage S1).
// vis_c exposes the unregistered visibility decode so the read port can share S1.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP
) (
    input  logic               clk,
    input  logic               rst,
    output logic [H_CNT_W-1:0] h_cnt,
    output logic [V_CNT_W-1:0] v_cnt,
    output logic               vis_c,
    output vga_dec_t           dec
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic     h_last;
    logic     v_last;
    vga_dec_t dec_c;

    assign h_last = (h_cnt == H_CNT_W'(H_TOTAL - 1));
    assign v_last = (v_cnt == V_CNT_W'(V_TOTAL - 1));

    // Line counter advances only on the horizontal wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_last ? '0 : h_cnt + H_CNT_W'(1);
            if (h_last) begin
                v_cnt <= v_last ? '0 : v_cnt + V_CNT_W'(1);
            end
        end
    end

    always_comb begin
        dec_c      = DEC_IDLE;
        dec_c.vis  = (h_cnt < H_CNT_W'(H_ACTIVE)) && (v_cnt < V_CNT_W'(V_ACTIVE));
        dec_c.hs_n = !((h_cnt >= H_CNT_W'(HS_START)) && (h_cnt < H_CNT_W'(HS_END)));
        dec_c.vs_n = !((v_cnt >= V_CNT_W'(VS_START)) && (v_cnt < V_CNT_W'(VS_END)));
        dec_c.fs   = (h_cnt == '0) && (v_cnt == '0);
        dec_c.vb   = (v_cnt >= V_CNT_W'(V_ACTIVE));
    end

    assign vis_c = dec_c.vis;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec <= DEC_IDLE;
        end else begin
            dec <= dec_c;
        end
    end

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scanout: issues 4x4-replicated reads and aligns the RAM data with
// sync/blanking decodes so all display outputs land together, 3 clk after the counters.
module fb_scanout
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = VGA_H_ACTIVE,
    parameter int unsigned H_FP        = VGA_H_FP,
    parameter int unsigned H_SYNC      = VGA_H_SYNC,
    parameter int unsigned H_BP        = VGA_H_BP,
    parameter int unsigned V_ACTIVE    = VGA_V_ACTIVE,
    parameter int unsigned V_FP        = VGA_V_FP,
    parameter int unsigned V_SYNC      = VGA_V_SYNC,
    parameter int unsigned V_BP        = VGA_V_BP,
    parameter int unsigned SCALE_SHIFT = SCALE_SHIFT_DEF,
    parameter int unsigned PIX_W       = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rd_en,
    output logic [FB_X_W-1:0] rd_x,
    output logic [FB_Y_W-1:0] rd_y,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              hsync,
    output logic              vsync,
    output logic [PIX_W-1:0]  pixel_out,
    output logic              active,
    output logic              vblank,
    output logic              frame_start
);

    logic [H_CNT_W-1:0] h_cnt;
    logic [V_CNT_W-1:0] v_cnt;
    logic               vis_c;
    vga_dec_t           dec_s1;
    vga_dec_t           dec_s2;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk   (clk),
        .rst   (rst),
        .h_cnt (h_cnt),
        .v_cnt (v_cnt),
        .vis_c (vis_c),
        .dec   (dec_s1)
    );

    // S1 read port; the address holds during blanking so the RAM sees no spurious changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_en <= 1'b0;
            rd_x  <= '0;
            rd_y  <= '0;
        end else begin
            rd_en <= vis_c;
            if (vis_c) begin
                rd_x <= FB_X_W'(h_cnt >> SCALE_SHIFT);
                rd_y <= FB_Y_W'(v_cnt >> SCALE_SHIFT);
            end
        end
    end

    // S2 waits out the RAM read latency; S3 masks data and registers every display output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_s2      <= DEC_IDLE;
            pixel_out   <= '0;
            active      <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            vblank      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            dec_s2      <= dec_s1;
            pixel_out   <= dec_s2.vis ? rd_data : '0;
            active      <= dec_s2.vis;
            hsync       <= dec_s2.hs_n;
            vsync       <= dec_s2.vs_n;
            vblank      <= dec_s2.vb;
            frame_start <= dec_s2.fs;
        end
    end

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench: full-size scanout for line-level behaviour, plus a shrunken
// timing instance so complete frames and the frame wrap fit in a short run.
module tb_fb_scanout;
    import vga_pkg::*;

    localparam int D_HT = VGA_H_TOTAL;
    localparam int D_VT = VGA_V_TOTAL;
    localparam int D_HA = VGA_H_ACTIVE;
    localparam int D_VA = VGA_V_ACTIVE;

    localparam int S_HA = 16, S_HFP = 2, S_HS = 3, S_HBP = 3;
    localparam int S_VA = 8,  S_VFP = 1, S_VS = 2, S_VBP = 1;
    localparam int S_HT = S_HA + S_HFP + S_HS + S_HBP;
    localparam int S_VT = S_VA + S_VFP + S_VS + S_VBP;

    logic clk;
    logic rst;
    logic pat;

    logic       d_rd_en, d_hsync, d_vsync, d_active, d_vblank, d_fs;
    logic [7:0] d_rd_x;
    logic [6:0] d_rd_y;
    logic [0:0] d_rd_data, d_pix;

    logic       s_rd_en, s_hsync, s_vsync, s_active, s_vblank, s_fs;
    logic [7:0] s_rd_x;
    logic [6:0] s_rd_y;
    logic [0:0] s_rd_data, s_pix;

    int n_cmp;
    int n_bad;

    fb_scanout dut (
        .clk(clk), .rst(rst),
        .rd_en(d_rd_en), .rd_x(d_rd_x), .rd_y(d_rd_y), .rd_data(d_rd_data),
        .hsync(d_hsync), .vsync(d_vsync), .pixel_out(d_pix),
        .active(d_active), .vblank(d_vblank), .frame_start(d_fs)
    );

    fb_scanout #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
    ) dut_s (
        .clk(clk), .rst(rst),
        .rd_en(s_rd_en), .rd_x(s_rd_x), .rd_y(s_rd_y), .rd_data(s_rd_data),
        .hsync(s_hsync), .vsync(s_vsync), .pixel_out(s_pix),
        .active(s_active), .vblank(s_vblank), .frame_start(s_fs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 1-clk RAM models: constant 1 (pat=0) or x[0]^y[0] (pat=1), read every clk.
    always_ff @(posedge clk) begin
        d_rd_data <= pat ? (d_rd_x[0] ^ d_rd_y[0]) : 1'b1;
        s_rd_data <= pat ? (s_rd_x[0] ^ s_rd_y[0]) : 1'b1;
    end

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    // k = active edges since reset release (0 = still in reset / just reset).
    task automatic check_model(input bit sm, input int k);
        int ht, vt, ha, va, hs0, hs1, vs0, vs1, i, h, v;
        logic e_vis, e_pix, e_hs, e_vs, e_vb, e_fs, e_en;
        logic [7:0] e_x;
        logic [6:0] e_y;
        logic o_act, o_pix, o_hs, o_vs, o_vb, o_fs, o_en;
        logic [7:0] o_x;
        logic [6:0] o_y;
        string nm;
        if (sm) begin
            ht = S_HT; vt = S_VT; ha = S_HA; va = S_VA;
            hs0 = S_HA + S_HFP; hs1 = hs0 + S_HS; vs0 = S_VA + S_VFP; vs1 = vs0 + S_VS;
            o_act = s_active; o_pix = s_pix[0]; o_hs = s_hsync; o_vs = s_vsync;
            o_vb = s_vblank; o_fs = s_fs; o_en = s_rd_en; o_x = s_rd_x; o_y = s_rd_y;
            nm = "small.";
        end else begin
            ht = D_HT; vt = D_VT; ha = D_HA; va = D_VA;
            hs0 = 656; hs1 = 752; vs0 = 490; vs1 = 492;
            o_act = d_active; o_pix = d_pix[0]; o_hs = d_hsync; o_vs = d_vsync;
            o_vb = d_vblank; o_fs = d_fs; o_en = d_rd_en; o_x = d_rd_x; o_y = d_rd_y;
            nm = "full.";
        end
        e_vis = 1'b0; e_pix = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_vb = 1'b0; e_fs = 1'b0;
        if (k >= 3) begin
            i = k - 3; h = i % ht; v = (i / ht) % vt;
            e_vis = (h < ha) && (v < va);
            e_pix = e_vis & (pat ? 1'(((h >> 2) ^ (v >> 2)) & 1) : 1'b1);
            e_hs  = !((h >= hs0) && (h < hs1));
            e_vs  = !((v >= vs0) && (v < vs1));
            e_vb  = (v >= va);
            e_fs  = (h == 0) && (v == 0);
        end
        e_en = 1'b0; e_x = '0; e_y = '0;
        if (k >= 1) begin
            i = k - 1; h = i % ht; v = (i / ht) % vt;
            e_en = (h < ha) && (v < va);
            e_x = 8'(h >> 2);
            e_y = 7'(v >> 2);
        end
        chk({nm, "active"},      k, 32'(o_act), 32'(e_vis));
        chk({nm, "pixel_out"},   k, 32'(o_pix), 32'(e_pix));
        chk({nm, "hsync"},       k, 32'(o_hs),  32'(e_hs));
        chk({nm, "vsync"},       k, 32'(o_vs),  32'(e_vs));
        chk({nm, "vblank"},      k, 32'(o_vb),  32'(e_vb));
        chk({nm, "frame_start"}, k, 32'(o_fs),  32'(e_fs));
        chk({nm, "rd_en"},       k, 32'(o_en),  32'(e_en));
        if (e_en || k == 0) begin
            chk({nm, "rd_x"}, k, 32'(o_x), 32'(e_x));
            chk({nm, "rd_y"}, k, 32'(o_y), 32'(e_y));
        end
    endtask

    initial begin
        int act_cnt, hs_cnt, hs_first, fs1, fs2, smax_x, smax_y, dmax_x;
        n_cmp = 0; n_bad = 0;
        act_cnt = 0; hs_cnt = 0; hs_first = -1; fs1 = -1; fs2 = -1;
        smax_x = 0; smax_y = 0; dmax_x = 0;
        pat = 1'b0;
        rst = 1'b1;

        // Power-up reset with constant-1 RAM data.
        repeat (3) @(posedge clk);
        #1;
        check_model(1'b0, 0);
        check_model(1'b1, 0);
        rst = 1'b0;

        // Phase A: first 1100 edges; constant data must only appear while active.
        for (int k = 1; k <= 1100; k++) begin
            @(posedge clk);
            #1;
            check_model(1'b0, k);
            check_model(1'b1, k);
            if (k >= 3 && k <= 802) begin
                if (d_active) act_cnt++;
                if (!d_hsync) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = k;
                end
            end
            if (s_fs) begin
                if (fs1 < 0) fs1 = k;
                else if (fs2 < 0) fs2 = k;
            end
            if (s_rd_en) begin
                if (int'(s_rd_x) > smax_x) smax_x = int'(s_rd_x);
                if (int'(s_rd_y) > smax_y) smax_y = int'(s_rd_y);
            end
        end
        chk("full.line0_active_clks", 802, act_cnt, 640);
        chk("full.line0_hsync_low_clks", 802, hs_cnt, 96);
        chk("full.hsync_fall_offset", 802, hs_first - 3, 656);
        chk("small.first_frame_start_edge", 1100, fs1, 3);
        chk("small.frame_period", 1100, fs2 - fs1, S_HT * S_VT);
        chk("small.rd_x_max", 1100, smax_x, 3);
        chk("small.rd_y_max", 1100, smax_y, 1);

        // Asynchronous reset mid-line (full instance at h=300): outputs clear at once.
        #3;
        rst = 1'b1;
        #1;
        check_model(1'b0, 0);
        check_model(1'b1, 0);
        pat = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Phase B: restart from (0,0) with x[0]^y[0] pattern data.
        for (int k = 1; k <= 6500; k++) begin
            @(posedge clk);
            #1;
            check_model(1'b0, k);
            check_model(1'b1, k);
            if (d_rd_en && int'(d_rd_x) > dmax_x) dmax_x = int'(d_rd_x);
        end
        chk("full.rd_x_max", 6500, dmax_x, 159);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
